// File: rtl/uart_tx_fc.sv
// uart_tx_fc: 8N1 UART transmitter with a small input FIFO and CTS flow control.
// Bytes enter through a valid/ready handshake, wait in the FIFO, and are sent
// LSB-first. A new frame starts only while the far end holds cts_n low; a frame
// already on the line always runs to the end of its stop bit.
module uart_tx_fc #(
   parameter int CLK_FREQ        = 12000000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     cts_n,
   output logic                     tx,
   output logic                     busy,
   output logic [FIFO_DEPTH_LOG2:0] fifo_level,
   output logic                     overrun
);

   localparam int TICKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W         = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam int DEPTH         = 1 << FIFO_DEPTH_LOG2;
   localparam int LVL_W         = FIFO_DEPTH_LOG2 + 1;

   localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(TICKS_PER_BIT - 1);
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                     state;
   state_t                     state_next;

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic                       push;
   logic                       pop;

   logic                       cts_meta;
   logic                       cts_s;

   logic [CNT_W-1:0]           baud_cnt;
   logic                       bit_done;
   logic [2:0]                 bit_idx;
   logic [7:0]                 shift;
   logic                       tx_next;

   // in_ready comes straight from the registered level, so a slot freed by a
   // pop only becomes writable on the following cycle.
   assign in_ready = (fifo_level != FULL_LEVEL);
   assign push     = in_valid && in_ready;
   assign busy     = (state != IDLE);
   assign bit_done = (baud_cnt == LAST_TICK);

   // Two-flop synchroniser for the asynchronous cts_n; resets to "not clear".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cts_meta <= 1'b1;
         cts_s    <= 1'b1;
      end else begin
         cts_meta <= cts_n;
         cts_s    <= cts_meta;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset here.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the depth.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Sticky overrun flag: any write offered while the FIFO is full is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (in_valid && !in_ready) begin
         overrun <= 1'b1;
      end
   end

   // Frame state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, pop decision and line level; CTS is only consulted in IDLE.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      tx_next    = 1'b1;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if ((fifo_level != '0) && !cts_s) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (bit_done) begin
               state_next = DATA;
            end
         end
         DATA: begin
            tx_next = shift[0];
            if (bit_done && (bit_idx == 3'd7)) begin
               state_next = STOP;
            end
         end
         STOP: begin
            tx_next = 1'b1;
            if (bit_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Baud counter, bit index and shift register; IDLE holds them cleared so
   // each frame starts on a fresh bit boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         if (state == IDLE || bit_done) begin
            baud_cnt <= '0;
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end

         if (state != DATA) begin
            bit_idx <= '0;
         end else if (bit_done) begin
            bit_idx <= bit_idx + 1'b1;
         end

         if (pop) begin
            shift <= mem[rd_ptr];
         end else if (state == DATA && bit_done) begin
            shift <= {1'b0, shift[7:1]};
         end
      end
   end

   // Registered serial output; reset forces the line idle immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx <= 1'b1;
      end else begin
         tx <= tx_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_fc.sv
// tb_uart_tx_fc: self-checking bench for uart_tx_fc. A line monitor decodes
// every frame from tx alone and compares it against a queue of bytes the bench
// expects to be sent; timing is checked from recorded cycle numbers.
module tb_uart_tx_fc;

   localparam int T     = 104;
   localparam int FRAME = 10 * T;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       cts_n;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_level;
   logic       overrun;

   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;

   logic [7:0] exp_q[$];
   int         fall_q[$];
   logic [7:0] mon_data;

   uart_tx_fc #(
      .CLK_FREQ       (12000000),
      .BAUD_RATE      (115200),
      .FIFO_DEPTH_LOG2(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cts_n     (cts_n),
      .tx        (tx),
      .busy      (busy),
      .fifo_level(fifo_level),
      .overrun   (overrun)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle number used for latency and spacing measurements
   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: decode each frame at bit centres, check start/stop, compare data
   initial begin : monitor
      bit         aborted;
      int         idx;
      logic [7:0] expb;
      forever begin
         @(negedge tx);
         #1;
         fall_q.push_back(cyc);
         aborted  = 1'b0;
         mon_data = '0;
         for (int n = 1; n <= T / 2 + 9 * T; n++) begin
            @(negedge clk);
            if (reset) begin
               aborted = 1'b1;
               break;
            end
            if (n == T / 2) begin
               checks++;
               if (tx !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL start_bit: tx=%b at start-bit centre, required 0", tx);
               end
            end else if (n > T / 2 && ((n - T / 2) % T) == 0) begin
               idx = (n - T / 2) / T;
               if (idx <= 8) begin
                  mon_data[3'(idx - 1)] = tx;
               end else begin
                  checks++;
                  if (tx !== 1'b1) begin
                     errors++;
                     $display("[TB] FAIL stop_bit: tx=%b at stop-bit centre, required 1", tx);
                  end
               end
            end
         end
         if (!aborted) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL frame_data: unexpected frame 0x%02h, required no frame", mon_data);
            end else begin
               expb = exp_q.pop_front();
               if (mon_data !== expb) begin
                  errors++;
                  $display("[TB] FAIL frame_data: got 0x%02h, required 0x%02h", mon_data, expb);
               end
            end
         end
      end
   end

   // Hard time limit so the run can never hang
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: time limit reached with %0d errors, required completion", errors);
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("[TB] FAIL %s_drain: %0d bytes pending busy=%b after %0d clocks, required 0 pending and idle",
                  name, exp_q.size(), busy, n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 5;
      if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b, required 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
      if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d, required 0", fifo_level); end
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b, required 0", overrun); end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      int acc;
      int n;
      int len;
      $display("[TB] single byte 0x55");
      fall_q.delete();
      in_data  = 8'h55;
      in_valid = 1'b1;
      @(posedge clk);
      #1 acc = cyc;
      exp_q.push_back(8'h55);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      len = 0;
      while (busy === 1'b1 && len < 2000) begin len++; @(negedge clk); end
      checks++;
      if (len != FRAME) begin
         errors++;
         $display("[TB] FAIL busy_length: got %0d clocks, required %0d", len, FRAME);
      end
      checks++;
      if (fall_q.size() < 1) begin
         errors++;
         $display("[TB] FAIL start_latency: no falling edge seen, required one at +2 clocks");
      end else if (fall_q[0] - acc != 2) begin
         errors++;
         $display("[TB] FAIL start_latency: got %0d clocks, required 2", fall_q[0] - acc);
      end
      wait_drain(200, "single");
      checks++;
      if (fifo_level !== 3'd0) begin
         errors++;
         $display("[TB] FAIL single_level: got %0d, required 0", fifo_level);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b [3];
      b[0] = 8'hA3;
      b[1] = 8'h0F;
      b[2] = 8'hFF;
      $display("[TB] back-to-back bytes");
      fall_q.delete();
      for (int i = 0; i < 3; i++) begin
         in_data  = b[i];
         in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready: byte %0d got %b, required 1", i, in_ready);
         end
         exp_q.push_back(b[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_drain(4000, "b2b");
      checks++;
      if (fall_q.size() != 3) begin
         errors++;
         $display("[TB] FAIL b2b_frames: got %0d frames, required 3", fall_q.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (fall_q[i] - fall_q[i - 1] != FRAME + 1) begin
               errors++;
               $display("[TB] FAIL b2b_spacing: got %0d clocks, required %0d",
                        fall_q[i] - fall_q[i - 1], FRAME + 1);
            end
         end
      end
   endtask

   task automatic test_cts_hold();
      int         mlevel = 0;
      int         viol   = 0;
      int         c0;
      logic [7:0] d;
      $display("[TB] CTS held off, FIFO fill and overflow");
      cts_n = 1'b1;
      repeat (3) @(negedge clk);
      fall_q.delete();
      for (int i = 0; i < 5; i++) begin
         d        = 8'($urandom);
         in_data  = d;
         in_valid = 1'b1;
         checks++;
         if (in_ready !== (mlevel != 4)) begin
            errors++;
            $display("[TB] FAIL hold_in_ready: byte %0d got %b, required %b", i, in_ready, mlevel != 4);
         end
         if (mlevel != 4) begin
            exp_q.push_back(d);
            mlevel++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks += 3;
      if (fifo_level !== 3'(mlevel)) begin errors++; $display("[TB] FAIL hold_level: got %0d, required %0d", fifo_level, mlevel); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_full_ready: got %b, required 0", in_ready); end
      if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL hold_overrun: got %b, required 1", overrun); end
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("[TB] FAIL hold_line_idle: %0d active clocks, required 0", viol);
      end
      cts_n = 1'b0;
      c0    = cyc;
      wait_drain(6000, "hold");
      checks++;
      if (fall_q.size() != 4) begin
         errors++;
         $display("[TB] FAIL hold_frames: got %0d frames, required 4", fall_q.size());
      end else if (fall_q[0] - c0 != 4) begin
         errors++;
         $display("[TB] FAIL hold_release_latency: got %0d clocks, required 4", fall_q[0] - c0);
      end
   endtask

   task automatic test_cts_midframe();
      int n;
      int viol = 0;
      int c0;
      int target;
      $display("[TB] CTS raised mid-frame");
      cts_n = 1'b0;
      fall_q.delete();
      for (int i = 0; i < 3; i++) begin
         in_data  = 8'($urandom);
         in_valid = 1'b1;
         exp_q.push_back(in_data);
         @(negedge clk);
      end
      in_valid = 1'b0;
      n = 0;
      while (fall_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (fall_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL mid_first_start: no frame within 20 clocks, required one");
      end else begin
         target = fall_q[0] + 4 * T + T / 2;
         n = 0;
         while (cyc < target && n < 2000) begin @(negedge clk); n++; end
         cts_n = 1'b1;
         n = 0;
         while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
         checks += 2;
         if (exp_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL mid_frame_complete: %0d bytes still pending, required 2", exp_q.size());
         end
         if (fifo_level !== 3'd2) begin
            errors++;
            $display("[TB] FAIL mid_level: got %0d, required 2", fifo_level);
         end
         repeat (3 * T) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
         end
         checks++;
         if (viol != 0) begin
            errors++;
            $display("[TB] FAIL mid_paused: %0d active clocks, required 0", viol);
         end
         cts_n = 1'b0;
         c0    = cyc;
         wait_drain(4000, "mid");
         checks++;
         if (fall_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL mid_frames: got %0d frames, required 3", fall_q.size());
         end else if (fall_q[1] - c0 != 4) begin
            errors++;
            $display("[TB] FAIL mid_resume_latency: got %0d clocks, required 4", fall_q[1] - c0);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int n;
      int target;
      $display("[TB] reset during a data bit");
      cts_n = 1'b0;
      fall_q.delete();
      for (int i = 0; i < 2; i++) begin
         in_data  = 8'($urandom);
         in_valid = 1'b1;
         exp_q.push_back(in_data);
         @(negedge clk);
      end
      in_valid = 1'b0;
      n = 0;
      while (fall_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
      target = (fall_q.size() != 0) ? fall_q[0] + 5 * T + T / 2 : cyc;
      n = 0;
      while (cyc < target && n < 2000) begin @(negedge clk); n++; end
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      checks += 4;
      if (tx !== 1'b1) begin errors++; $display("[TB] FAIL abort_tx: got %b, required 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, required 0", busy); end
      if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL abort_level: got %0d, required 0", fifo_level); end
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL abort_overrun: got %b, required 0", overrun); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      fall_q.delete();
      in_data  = 8'h81;
      in_valid = 1'b1;
      exp_q.push_back(8'h81);
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain(2000, "after_abort");
      checks++;
      if (fall_q.size() != 1) begin
         errors++;
         $display("[TB] FAIL after_abort_frames: got %0d frames, required 1", fall_q.size());
      end
   endtask

   task automatic test_full_pop();
      int n = 0;
      $display("[TB] push into full FIFO on the pop cycle");
      cts_n = 1'b1;
      do_reset();
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL fp_overrun_clear: got %b, required 0", overrun); end
      for (int i = 0; i < 4; i++) begin
         in_data  = 8'($urandom);
         in_valid = 1'b1;
         exp_q.push_back(in_data);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL fp_full_level: got %0d, required 4", fifo_level); end
      cts_n    = 1'b0;
      in_data  = 8'h3C;
      in_valid = 1'b1;
      while (fifo_level === 3'd4 && n < 20) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fp_in_ready: got %b while full, required 0", in_ready);
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      checks += 2;
      if (fifo_level !== 3'd3) begin errors++; $display("[TB] FAIL fp_level_after_pop: got %0d, required 3", fifo_level); end
      if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL fp_overrun: got %b, required 1", overrun); end
      wait_drain(6000, "full_pop");
   endtask

   // Run every scenario in order, then report
   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      cts_n    = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_cts_hold();
      test_cts_midframe();
      test_reset_midframe();
      test_full_pop();
      repeat (10) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
